// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : byte-serial memory responder for fetch and load/store ports
// Rev 1.0
// ============================================================================
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              enable_from_if,
  input  logic [ADDR_W-1:0] addr_from_if,
  output logic              ok_to_if,
  output logic [31:0]       ins_to_if,
  input  logic              enable_from_lsb,
  input  logic              wr_from_lsb,
  input  logic [ADDR_W-1:0] addr_from_lsb,
  input  logic [2:0]        size_from_lsb,
  input  logic [31:0]       data_from_lsb,
  output logic              ok_to_lsb,
  output logic [31:0]       data_to_lsb,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         buf_q, buf_d;
  logic                src_lsb_q, src_lsb_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                ok_if_q, ok_if_d;
  logic                ok_lsb_q, ok_lsb_d;
  logic [31:0]         ins_q, ins_d;
  logic [31:0]         ldata_q, ldata_d;
  logic                rdy_q;
  logic [7:0]          din_hold_q;

  logic                io_stall;
  logic [7:0]          din;
  logic [1:0]          rd_idx;

  assign io_stall = (addr_q[17:16] == IO_HI) && io_buffer_full;
  // After a freeze mem_a has not moved, so the byte for the previous address
  // is the one captured on the first frozen cycle.
  assign din      = rdy_q ? mem_din : din_hold_q;
  assign rd_idx   = 2'(cnt_q - 3'd2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    src_lsb_d  = src_lsb_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ok_if_d    = 1'b0;
    ok_lsb_d   = 1'b0;
    ins_d      = ins_q;
    ldata_d    = ldata_q;
    case (state_q)
      IDLE: begin
        if (enable_from_lsb) begin
          addr_d    = addr_from_lsb;
          size_d    = size_from_lsb;
          wdata_d   = data_from_lsb;
          src_lsb_d = 1'b1;
          cnt_d     = 3'd1;
          buf_d     = '0;
          mem_a_d   = addr_from_lsb;
          if (wr_from_lsb) begin
            state_d    = WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = data_from_lsb[7:0];
          end else begin
            state_d = READ;
          end
        end else if (enable_from_if) begin
          addr_d    = addr_from_if;
          size_d    = 3'd4;
          src_lsb_d = 1'b0;
          cnt_d     = 3'd1;
          buf_d     = '0;
          mem_a_d   = addr_from_if;
          state_d   = READ;
        end
      end
      READ: begin
        cnt_d   = 3'(cnt_q + 3'd1);
        mem_a_d = (cnt_q < size_q) ? addr_q + ADDR_W'(cnt_q) : '0;
        if (cnt_q >= 3'd2)
          buf_d[{rd_idx, 3'b000} +: 8] = din;
        if (cnt_q == 3'(size_q + 3'd1)) begin
          state_d = DONE;
          if (src_lsb_q) begin
            ok_lsb_d = 1'b1;
            ldata_d  = buf_d;
          end else begin
            ok_if_d = 1'b1;
            ins_d   = buf_d;
          end
        end
      end
      WRITE: begin
        if (!io_stall) begin
          if (cnt_q < size_q) begin
            mem_a_d    = addr_q + ADDR_W'(cnt_q);
            mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d      = 3'(cnt_q + 3'd1);
          end else begin
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            mem_dout_d = '0;
            ok_lsb_d   = 1'b1;
            state_d    = DONE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      src_lsb_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ok_if_q    <= 1'b0;
      ok_lsb_q   <= 1'b0;
      ins_q      <= '0;
      ldata_q    <= '0;
      rdy_q      <= 1'b1;
      din_hold_q <= '0;
    end else begin
      rdy_q <= rdy;
      if (!rdy && rdy_q)
        din_hold_q <= mem_din;
      if (rdy) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        size_q     <= size_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        buf_q      <= buf_d;
        src_lsb_q  <= src_lsb_d;
        mem_a_q    <= mem_a_d;
        mem_dout_q <= mem_dout_d;
        mem_wr_q   <= mem_wr_d;
        ok_if_q    <= ok_if_d;
        ok_lsb_q   <= ok_lsb_d;
        ins_q      <= ins_d;
        ldata_q    <= ldata_d;
      end
    end
  end

  assign mem_wr      = mem_wr_q && rdy && !((state_q == WRITE) && io_stall);
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign ok_to_if    = ok_if_q;
  assign ok_to_lsb   = ok_lsb_q;
  assign ins_to_if   = ins_q;
  assign data_to_lsb = ldata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : directed and randomized checks of mem_ctrl against a byte RAM
// Rev 1.0
// ============================================================================
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        enable_from_if;
  logic [31:0] addr_from_if;
  logic        ok_to_if;
  logic [31:0] ins_to_if;
  logic        enable_from_lsb, wr_from_lsb;
  logic [31:0] addr_from_lsb;
  logic [2:0]  size_from_lsb;
  logic [31:0] data_from_lsb;
  logic        ok_to_lsb;
  logic [31:0] data_to_lsb;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram    [0:1023];
  logic [7:0]  shadow [0:1023];
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ins, exp_ldata;

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_from_if(enable_from_if), .addr_from_if(addr_from_if),
    .ok_to_if(ok_to_if), .ins_to_if(ins_to_if),
    .enable_from_lsb(enable_from_lsb), .wr_from_lsb(wr_from_lsb),
    .addr_from_lsb(addr_from_lsb), .size_from_lsb(size_from_lsb),
    .data_from_lsb(data_from_lsb), .ok_to_lsb(ok_to_lsb), .data_to_lsb(data_to_lsb),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM aliased on the low 10 address bits; read data one cycle after mem_a
  always @(posedge clk) begin
    if (pl_we)
      ram[pl_addr] <= pl_data;
    else if (mem_wr)
      ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] v);
    pl_we = 1'b1; pl_addr = a; pl_data = v;
    shadow[a] = v;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ok_if"},  ok_to_if,    0);
    chk({tag, "_ok_lsb"}, ok_to_lsb,   0);
    chk({tag, "_ins"},    ins_to_if,   0);
    chk({tag, "_ldata"},  data_to_lsb, 0);
    chk({tag, "_mem_a"},  mem_a,       0);
    chk({tag, "_mem_wr"}, mem_wr,      0);
    chk({tag, "_dout"},   mem_dout,    0);
  endtask

  // One request from its accept cycle (cycle 0, now) to the cycle after its ok.
  task automatic run_txn(input bit lsb, input bit wr, input logic [31:0] a, input int n,
                         input logic [31:0] d, input int io_full, input bit io_rand,
                         input int stall_at);
    logic [31:0] exp_w, t;
    int          e, wcnt, cyc;
    bit          done, io_reg, was_rdy;
    exp_w = '0;
    for (int k = 0; k < n; k++) begin
      t = a + 32'(k);
      if (wr) shadow[t[9:0]] = d[8*k +: 8];
      else    exp_w[8*k +: 8] = shadow[t[9:0]];
    end
    io_reg = wr && (a[17:16] == 2'b11);
    if (lsb) begin
      enable_from_lsb = 1'b1; wr_from_lsb = wr; addr_from_lsb = a;
      size_from_lsb = 3'(n); data_from_lsb = d;
    end else begin
      enable_from_if = 1'b1; addr_from_if = a;
    end
    e = 0; wcnt = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      was_rdy = rdy;
      @(posedge clk); #1;
      cyc++;
      if (was_rdy) e++;
      rdy = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3);
      io_buffer_full = (cyc <= io_full) || (io_rand && $urandom_range(1, 0) == 1);
      @(negedge clk);
      if (wr) begin
        if (wcnt < n) begin
          chk("st_addr", mem_a, a + 32'(wcnt));
          if (rdy && !(io_reg && io_buffer_full)) begin
            chk("st_wr", mem_wr, 1);
            chk("st_dout", mem_dout, d[8*wcnt +: 8]);
            wcnt++;
          end else begin
            chk("st_wr_stall", mem_wr, 0);
          end
          chk("st_ok_early", ok_to_lsb, 0);
        end else begin
          chk("st_ok", ok_to_lsb, 1);
          chk("st_wr_done", mem_wr, 0);
          chk("st_hold_ldata", data_to_lsb, exp_ldata);
          chk("st_hold_ins", ins_to_if, exp_ins);
          done = 1'b1;
        end
      end else begin
        if (e >= 1 && e <= n)
          chk("ld_addr", mem_a, a + 32'(e - 1));
        chk("ld_no_wr", mem_wr, 0);
        if (e == n + 2) begin
          if (lsb) begin
            exp_ldata = exp_w;
            chk("ld_ok", ok_to_lsb, 1);
          end else begin
            exp_ins = exp_w;
            chk("if_ok", ok_to_if, 1);
          end
          chk("ld_data", data_to_lsb, exp_ldata);
          chk("if_data", ins_to_if, exp_ins);
          done = 1'b1;
        end else begin
          chk("ok_early", lsb ? ok_to_lsb : ok_to_if, 0);
        end
      end
      chk("ok_other", lsb ? ok_to_if : ok_to_lsb, 0);
      if (!done && cyc > 80) begin
        checks++; errors++;
        $error("FAIL timeout: observed no ok after %0d cycles, expected ok", cyc);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (lsb) enable_from_lsb = 1'b0;
    else     enable_from_if  = 1'b0;
    rdy = 1'b1; io_buffer_full = 1'b0;
    chk("no_double_ok", ok_to_if | ok_to_lsb, 0);
  endtask

  initial begin
    int          n;
    bit          lsbr, wrr;
    logic [31:0] a;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    enable_from_if = 1'b0; addr_from_if = '0;
    enable_from_lsb = 1'b0; wr_from_lsb = 1'b0; addr_from_lsb = '0;
    size_from_lsb = '0; data_from_lsb = '0;
    exp_ins = '0; exp_ldata = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) poke(10'(i), 8'($urandom));
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h00); poke(10'h103, 8'h00);
    poke(10'h007, 8'hF0);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(1'b0, 1'b0, 32'h100, 4, 32'h0, 0, 1'b0, 0);
    chk("if_word_0x100", ins_to_if, 32'h0000_0513);
    run_txn(1'b1, 1'b0, 32'h7, 1, 32'h0, 0, 1'b0, 0);
    chk("lsb_byte_0x7", data_to_lsb, 32'h0000_00F0);
    run_txn(1'b1, 1'b1, 32'h20, 2, 32'hDEAD_BEEF, 0, 1'b0, 0);
    run_txn(1'b1, 1'b0, 32'h20, 4, 32'h0, 0, 1'b0, 0);

    // simultaneous requests: IF stays asserted across the whole LSB access
    enable_from_if = 1'b1; addr_from_if = 32'h100;
    run_txn(1'b1, 1'b0, 32'h6, 2, 32'h0, 0, 1'b0, 0);
    run_txn(1'b0, 1'b0, 32'h100, 4, 32'h0, 0, 1'b0, 0);

    run_txn(1'b1, 1'b1, 32'h0003_0000, 1, 32'h5A, 5, 1'b0, 0);
    run_txn(1'b1, 1'b0, 32'h0003_0000, 1, 32'h0, 0, 1'b0, 0);
    run_txn(1'b0, 1'b0, 32'h100, 4, 32'h0, 0, 1'b0, 2);
    chk("if_word_after_freeze", ins_to_if, 32'h0000_0513);
    run_txn(1'b1, 1'b0, 32'hFFFF_FFFE, 4, 32'h0, 0, 1'b0, 0);
    run_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 4, 32'h1234_5678, 0, 1'b0, 0);
    run_txn(1'b1, 1'b0, 32'hFFFF_FFFF, 4, 32'h0, 0, 1'b0, 0);

    // reset in the middle of a fetch
    enable_from_if = 1'b1; addr_from_if = 32'h200;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; enable_from_if = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ins = '0; exp_ldata = '0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      lsbr = 1'($urandom_range(1, 0));
      wrr  = lsbr && ($urandom_range(1, 0) == 1);
      case ($urandom_range(2, 0))
        0:       n = 1;
        1:       n = 2;
        default: n = 4;
      endcase
      if (!lsbr) n = 4;
      a = $urandom;
      run_txn(lsbr, wrr, a, n, $urandom, 0, 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
